// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and field positions for the PS/2 mouse decoder
// Contents: decoder FSM state enum, 11-bit frame field positions,
// IntelliMouse status byte bit indices.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      APPLY = 2'd2
   } state_e;

   // Frame field positions, MSB is the first bit on the wire.
   localparam int START_BIT = 10;
   localparam int DATA_MSB  = 9;
   localparam int DATA_LSB  = 2;
   localparam int PAR_BIT   = 1;
   localparam int STOP_BIT  = 0;

   // Status byte bit indices.
   localparam int ST_LEFT   = 0;
   localparam int ST_RIGHT  = 1;
   localparam int ST_MIDDLE = 2;
   localparam int SYNC_BIT  = 3;
   localparam int ST_XSIGN  = 4;
   localparam int ST_YSIGN  = 5;
   localparam int ST_XOVF   = 6;
   localparam int ST_YOVF   = 7;

endpackage

// File: rtl/ps2_frame_check.sv
// rtl/ps2_frame_check.sv - combinational validation and byte extraction of one PS/2 frame
// Ports:
//   i_frame  in  11  captured frame, start bit in bit 10
//   o_data   out 8   data byte (d0 in bit 0)
//   o_ok     out 1   start==0, stop==1 and odd parity over data+parity
module ps2_frame_check
   import ps2_pkg::*;
(
   input  logic [10:0] i_frame,
   output logic [7:0]  o_data,
   output logic        o_ok
);

   always_comb begin
      // d0 arrived first, so it sits at the top of the data field.
      for (int i = 0; i < 8; i++) begin
         o_data[i] = i_frame[DATA_MSB - i];
      end
      o_ok = ~i_frame[START_BIT] & i_frame[STOP_BIT]
           & (^{i_frame[DATA_MSB:DATA_LSB], i_frame[PAR_BIT]});
   end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// rtl/ps2_mouse_decoder.sv - validates 4-frame IntelliMouse packets and tracks a clamped cursor
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_word1..i_word4  in  11  status, X, Y, wheel frames; valid only while i_ready
//   i_ready           in  1   single-cycle packet strobe
//   o_x, o_y          out     cursor position (o_y = 0 is the top row)
//   o_buttons         out 3   {middle, right, left}
//   o_wheel           out 4   signed wheel delta of the last good packet
//   o_valid           out 1   pulse while freshly applied state is shown
//   o_frame_err       out 1   pulse when a packet is rejected
//   o_err_count       out 8   saturating rejected-packet count
module ps2_mouse_decoder
   import ps2_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int POS_W    = 10
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [10:0]      i_word1,
   input  logic [10:0]      i_word2,
   input  logic [10:0]      i_word3,
   input  logic [10:0]      i_word4,
   input  logic             i_ready,
   output logic [POS_W-1:0] o_x,
   output logic [POS_W-1:0] o_y,
   output logic [2:0]       o_buttons,
   output logic [3:0]       o_wheel,
   output logic             o_valid,
   output logic             o_frame_err,
   output logic [7:0]       o_err_count
);

   localparam int CW = POS_W + 2;
   localparam logic signed [CW-1:0] X_MAX = CW'(SCREEN_W - 1);
   localparam logic signed [CW-1:0] Y_MAX = CW'(SCREEN_H - 1);

   state_e                 state_q, state_d;
   logic [3:0][10:0]       word_q, word_d;
   logic [POS_W-1:0]       x_q, x_d, y_q, y_d;
   logic [2:0]             buttons_q, buttons_d;
   logic [3:0]             wheel_q, wheel_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [7:0]             err_count_q, err_count_d;

   logic [3:0][10:0]       in_words;
   logic [3:0][10:0]       chk_frame;
   logic [3:0][7:0]        chk_data;
   logic [3:0]             chk_ok;
   logic                   pkt_ok;
   logic                   unused_wheel_hi;

   logic [8:0]             dx9, dy9;
   logic signed [CW-1:0]   x_sum, y_sum;
   logic [POS_W-1:0]       x_clamp, y_clamp;

   assign in_words = {i_word4, i_word3, i_word2, i_word1};

   // The checkers look at the live inputs while idle so a bad packet can be
   // flagged on the capture edge; afterwards they decode the latched copy.
   assign chk_frame = (state_q == IDLE) ? in_words : word_q;

   for (genvar g = 0; g < 4; g++) begin : g_chk
      ps2_frame_check u_chk (
         .i_frame (chk_frame[g]),
         .o_data  (chk_data[g]),
         .o_ok    (chk_ok[g])
      );
   end

   assign pkt_ok          = (&chk_ok) & chk_data[0][SYNC_BIT];
   assign unused_wheel_hi = ^chk_data[3][7:4];

   always_comb begin
      // 9-bit two's complement deltas; overflow discards the movement.
      dx9 = chk_data[0][ST_XOVF] ? 9'd0 : {chk_data[0][ST_XSIGN], chk_data[1]};
      dy9 = chk_data[0][ST_YOVF] ? 9'd0 : {chk_data[0][ST_YSIGN], chk_data[2]};

      // Two guard bits keep the sum from wrapping before the clamp.
      x_sum = $signed({2'b00, x_q}) + CW'($signed(dx9));
      y_sum = $signed({2'b00, y_q}) - CW'($signed(dy9));

      if (x_sum[CW-1])       x_clamp = '0;
      else if (x_sum > X_MAX) x_clamp = POS_W'(SCREEN_W - 1);
      else                   x_clamp = x_sum[POS_W-1:0];

      if (y_sum[CW-1])       y_clamp = '0;
      else if (y_sum > Y_MAX) y_clamp = POS_W'(SCREEN_H - 1);
      else                   y_clamp = y_sum[POS_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      x_d         = x_q;
      y_d         = y_q;
      buttons_d   = buttons_q;
      wheel_d     = wheel_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      err_count_d = err_count_q;

      case (state_q)
         IDLE: begin
            if (i_ready) begin
               // Upstream clears the words next cycle, so capture them now.
               word_d  = in_words;
               state_d = CHECK;
               if (!pkt_ok) begin
                  frame_err_d = 1'b1;
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
               end
            end
         end
         CHECK: begin
            if (pkt_ok) begin
               x_d       = x_clamp;
               y_d       = y_clamp;
               buttons_d = {chk_data[0][ST_MIDDLE], chk_data[0][ST_RIGHT], chk_data[0][ST_LEFT]};
               wheel_d   = chk_data[3][3:0];
               valid_d   = 1'b1;
               state_d   = APPLY;
            end else begin
               state_d   = IDLE;
            end
         end
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         x_q         <= POS_W'(SCREEN_W / 2);
         y_q         <= POS_W'(SCREEN_H / 2);
         buttons_q   <= '0;
         wheel_q     <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         x_q         <= x_d;
         y_q         <= y_d;
         buttons_q   <= buttons_d;
         wheel_q     <= wheel_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign o_x         = x_q;
   assign o_y         = y_q;
   assign o_buttons   = buttons_q;
   assign o_wheel     = wheel_q;
   assign o_valid     = valid_q;
   assign o_frame_err = frame_err_q;
   assign o_err_count = err_count_q;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb/tb_ps2_mouse_decoder.sv - scoreboard bench for ps2_mouse_decoder
module tb_ps2_mouse_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
   logic        rdy = 1'b0;
   logic [9:0]  o_x, o_y;
   logic [2:0]  o_buttons;
   logic [3:0]  o_wheel;
   logic        o_valid, o_frame_err;
   logic [7:0]  o_err_count;

   ps2_mouse_decoder #(.SCREEN_W(640), .SCREEN_H(480), .POS_W(10)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_word1     (w1),
      .i_word2     (w2),
      .i_word3     (w3),
      .i_word4     (w4),
      .i_ready     (rdy),
      .o_x         (o_x),
      .o_y         (o_y),
      .o_buttons   (o_buttons),
      .o_wheel     (o_wheel),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_err_count (o_err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_err;
      int t;
      int x, y, btn, wheel, errc;
   } exp_t;

   exp_t exp_q[$];
   int   m_x = 320, m_y = 240, m_btn = 0, m_wheel = 0, m_err = 0;
   int   n_pass = 0, n_total = 0;

   task automatic chk(input string name, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input int bad_kind);
      logic [10:0] f;
      f[10] = 1'b0;
      for (int i = 0; i < 8; i++) f[9 - i] = b[i];
      f[1] = ~^b;
      f[0] = 1'b1;
      case (bad_kind)
         1: f[1]  = ~f[1];
         2: f[10] = 1'b1;
         3: f[0]  = 1'b0;
         default: ;
      endcase
      return f;
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Reference: decode the packet from the byte values and predict the response.
   function automatic void model(input logic [7:0] st, xb, yb, wb, input bit frames_ok, input int t);
      exp_t e;
      int dx, dy;
      if (!frames_ok || !st[3]) begin
         if (m_err < 255) m_err++;
         e.is_err = 1'b1;
         e.t = t + 1;
      end else begin
         dx = st[6] ? 0 : (st[4] ? int'(xb) - 256 : int'(xb));
         dy = st[7] ? 0 : (st[5] ? int'(yb) - 256 : int'(yb));
         m_x = clampi(m_x + dx, 639);
         m_y = clampi(m_y - dy, 479);
         m_btn = int'(st[2:0]);
         m_wheel = int'(wb[3:0]);
         e.is_err = 1'b0;
         e.t = t + 2;
      end
      e.x = m_x; e.y = m_y; e.btn = m_btn; e.wheel = m_wheel; e.errc = m_err;
      exp_q.push_back(e);
   endfunction

   // Drives in the current cycle (caller is just after a negedge).
   task automatic drive_now(input logic [7:0] st, xb, yb, wb, input int bad_frame, input int bad_kind,
                            input bit use_model);
      w1 = make_frame(st, bad_frame == 0 ? bad_kind : 0);
      w2 = make_frame(xb, bad_frame == 1 ? bad_kind : 0);
      w3 = make_frame(yb, bad_frame == 2 ? bad_kind : 0);
      w4 = make_frame(wb, bad_frame == 3 ? bad_kind : 0);
      rdy = 1'b1;
      if (use_model) model(st, xb, yb, wb, bad_frame < 0, cyc);
      @(negedge clk);
      rdy = 1'b0;
      w1 = '0; w2 = '0; w3 = '0; w4 = '0;
   endtask

   task automatic send(input logic [7:0] st, xb, yb, wb, input int bad_frame, input int bad_kind);
      @(negedge clk);
      drive_now(st, xb, yb, wb, bad_frame, bad_kind, 1'b1);
      repeat (3 + $urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_x"}, int'(o_x), 320);
      chk({tag, "_y"}, int'(o_y), 240);
      chk({tag, "_btn"}, int'(o_buttons), 0);
      chk({tag, "_wheel"}, int'(o_wheel), 0);
      chk({tag, "_valid"}, int'(o_valid), 0);
      chk({tag, "_ferr"}, int'(o_frame_err), 0);
      chk({tag, "_errc"}, int'(o_err_count), 0);
   endtask

   // Monitor: every output pulse must match the oldest prediction.
   always @(negedge clk) begin : mon
      exp_t e;
      if (o_valid && o_frame_err) chk("both_pulses", 1, 0);
      else if (o_valid || o_frame_err) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'(o_valid) * 2 + int'(o_frame_err), 0);
         end else begin
            e = exp_q.pop_front();
            chk("kind_err", int'(o_frame_err), int'(e.is_err));
            chk("latency", cyc, e.t);
            chk("x", int'(o_x), e.x);
            chk("y", int'(o_y), e.y);
            chk("buttons", int'(o_buttons), e.btn);
            chk("wheel", int'(o_wheel), e.wheel);
            chk("err_count", int'(o_err_count), e.errc);
         end
      end
   end

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] st;
      int bf;
      repeat (3) @(negedge clk);
      check_reset_values("reset");

      // Accepted in the very first cycle after release.
      rst_n = 1'b1;
      drive_now(8'h08, 8'h05, 8'h00, 8'h00, -1, 0, 1'b1);
      repeat (4) @(negedge clk);

      send(8'h29, 8'h00, 8'hF6, 8'h00, -1, 0);
      send(8'h08, 8'h00, 8'h00, 8'h00, 2, 1);   // parity error in word3
      send(8'h00, 8'h00, 8'h00, 8'h00, -1, 0);  // sync bit clear
      send(8'h48, 8'h10, 8'h00, 8'h03, -1, 0);  // X overflow

      for (int i = 0; i < 10; i++) send(8'h08, 8'h7F, 8'h00, 8'h00, -1, 0);
      chk("clamp_hi", int'(o_x), 639);
      for (int i = 0; i < 10; i++) send(8'h18, 8'h81, 8'h00, 8'h00, -1, 0);
      chk("clamp_lo", int'(o_x), 0);
      for (int i = 0; i < 10; i++) send(8'h28, 8'h00, 8'h81, 8'h00, -1, 0);
      chk("clamp_y_hi", int'(o_y), 479);

      // A second strobe while busy must be ignored.
      @(negedge clk);
      drive_now(8'h08, 8'h02, 8'h00, 8'h00, -1, 0, 1'b1);
      drive_now(8'h09, 8'h40, 8'h40, 8'h05, -1, 0, 1'b0);
      repeat (5) @(negedge clk);

      for (int i = 0; i < 200; i++) begin
         st = 8'($urandom);
         if ($urandom_range(0, 9) < 8) st[3] = 1'b1;
         bf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         send(st, 8'($urandom), 8'($urandom), 8'($urandom), bf, int'($urandom_range(1, 3)));
      end

      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         drive_now(8'h08, 8'h01, 8'h01, 8'h00, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b1);
         repeat (2) @(negedge clk);
      end
      @(negedge clk);
      chk("err_saturate", int'(o_err_count), 255);

      // Reset in the cycle after a good packet's strobe: packet is lost.
      @(negedge clk);
      drive_now(8'h09, 8'h10, 8'h10, 8'h01, -1, 0, 1'b0);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("midreset");
      m_x = 320; m_y = 240; m_btn = 0; m_wheel = 0; m_err = 0;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send(8'h0A, 8'hFE, 8'h02, 8'h0F, -1, 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ps2_mouse_decoder.md
# ps2_mouse_decoder

Consumes the four 11-bit PS/2 frames delivered by the PS/2 frame capture stage on each ready pulse. It validates every frame and decodes the 4-byte IntelliMouse packet (status, X, Y, wheel). It then updates a clamped on-screen cursor position, button state and wheel delta. It sits between the PS/2 serial capture and the display/cursor-overlay logic.

## Interface
Parameters:
- SCREEN_W, 640, horizontal extent; o_x range 0..SCREEN_W-1
- SCREEN_H, 480, vertical extent; o_y range 0..SCREEN_H-1
- POS_W, 10, width of o_x/o_y; must hold max(SCREEN_W, SCREEN_H)-1

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_word1  in  11  frame 1 (status byte)
- i_word2  in  11  frame 2 (X byte)
- i_word3  in  11  frame 3 (Y byte)
- i_word4  in  11  frame 4 (wheel byte)
- i_ready  in  1  single-cycle pulse; i_word1..4 are valid only in this cycle
- o_x  out  POS_W  cursor X
- o_y  out  POS_W  cursor Y (0 = top)
- o_buttons  out  3  {middle, right, left}
- o_wheel  out  4  signed wheel delta of the last good packet
- o_valid  out  1  one-cycle pulse after a good packet is applied
- o_frame_err  out  1  one-cycle pulse when a packet is rejected
- o_err_count  out  8  rejected-packet count, saturates at 255

## Operation
- Frame layout is MSB-first by arrival order:
  - bit10 = start
  - bits9..2 = d0..d7, so the data byte is the bit-reverse of word[9:2]
  - bit1 = parity
  - bit0 = stop
- A frame is good when all of these hold:
  - start == 0
  - stop == 1
  - d0..d7 plus parity contain an odd number of ones
- A packet is good when all four frames are good and status bit3 == 1 (sync bit).
- Status bits:
  - [0] left, [1] right, [2] middle
  - [4] X sign, [5] Y sign
  - [6] X overflow, [7] Y overflow
- Deltas:
  - dx = signed 9-bit {status[4], xbyte}; forced to 0 if status[6]
  - dy is built the same way from status[5] and status[7]
  - o_wheel = wheel byte [3:0]
- Position update:
  - x_new = clamp(x + dx, 0, SCREEN_W-1)
  - y_new = clamp(y - dy, 0, SCREEN_H-1), because PS/2 +Y means up
  - compute in signed POS_W+2 bits; no wrap-around is permitted
- FSM states:
  - IDLE: on i_ready, latch all four words → CHECK. The words must be latched that cycle because upstream zeroes them the next cycle.
  - CHECK: evaluate the frame/packet checks and compute the deltas. A good packet → APPLY. A bad packet pulses o_frame_err, increments o_err_count (saturating) → IDLE.
  - APPLY: write o_x, o_y, o_buttons, o_wheel; pulse o_valid → IDLE.
- An i_ready in CHECK or APPLY is ignored. Upstream spacing is at least 44 PS/2 bit-times, so this cannot occur in normal operation.
- A rejected packet leaves o_x, o_y, o_buttons and o_wheel unchanged.

## Timing
- Reset values:
  - o_x = SCREEN_W/2, o_y = SCREEN_H/2
  - o_buttons = 0, o_wheel = 0
  - o_valid = 0, o_frame_err = 0, o_err_count = 0
  - FSM = IDLE
- i_ready at cycle T (latched into the internal registers at the end of T):
  - o_frame_err is high during cycle T+1 for a bad packet
  - o_valid is high during cycle T+2 for a good packet
  - the new o_x, o_y, o_buttons and o_wheel are visible at T+2, the same cycle as o_valid
- All outputs are registered. o_valid and o_frame_err are never high together.
- Asserting reset at any point aborts CHECK/APPLY immediately. The packet is lost and no pulse is emitted.
- If i_ready is high in the first cycle after reset release, it is accepted.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, CHECK, APPLY)
  - frame field positions (START_BIT=10, DATA_MSB=9, DATA_LSB=2, PAR_BIT=1, STOP_BIT=0)
  - status bit indices
  - SYNC_BIT=3
- One sub-module: `ps2_frame_check`, combinational. It takes an 11-bit frame and outputs the 8-bit data byte plus an ok flag, and is instantiated four times.

## Test plan
- Good packet: status 0x08, X 0x05, Y 0x00, wheel 0x00 after reset → o_valid at T+2; o_x = 325, o_y = 240, o_buttons = 0.
- Negative Y with buttons: status 0x29, X 0x00, Y 0xF6 (dy = -10) → o_y = 250, o_buttons = 3'b001, o_x unchanged.
- Clamp: 10 packets of status 0x08, X 0x7F from reset → o_x saturates at 639 and never wraps; the same test with status 0x18, X 0x81 saturates at 0.
- Errors:
  - parity error in word3 → o_frame_err at T+1, o_err_count = 1, position unchanged
  - status 0x00 (sync bit clear) → rejected the same way
  - 300 bad packets → o_err_count holds at 255
- Overflow: status 0x48, X 0x10 → dx treated as 0, so o_x is unchanged and o_valid still pulses.
- Reset mid-operation: drop i_reset_n in the cycle after i_ready → all outputs return to their reset values, with no o_valid and no o_frame_err.
